// File: rtl/mtsp_alu_conv_issue.sv
// Request-side front end of the MTSP conversion ALU: issues MO_CONV micro-ops on
// alternating phase slots and returns ALU results in order through a credit-limited FIFO.
`ifndef MTSP_MODESC_DEFS
`define MTSP_MODESC_DEFS
// Descriptor layout: [6] nEN, [5:2] MO opcode, [1] ALT, [0] SEL.
`define MODESC_W 7
`define RANGE_MODESC 6:0
`define MO_CONV 4'd9
`endif

module mtsp_alu_conv_issue #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_OP,
  input  logic [31:0]          REQ_DATA,
  input  logic [TAG_W-1:0]     REQ_TAG,
  output logic [`RANGE_MODESC] MO0,
  output logic [`RANGE_MODESC] MO1,
  output logic                 MO0_MASK,
  output logic                 MO1_MASK,
  output logic [31:0]          SRC0A,
  output logic [31:0]          SRC0B,
  output logic [31:0]          SRC1A,
  output logic [31:0]          SRC1B,
  input  logic [1:0]           ALU_PHASE_EN,
  input  logic [31:0]          ALU_DOUT,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [31:0]          RSP_DATA,
  output logic [TAG_W-1:0]     RSP_TAG,
  output logic                 RSP_ERR,
  output logic                 ERR
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TOT_W = CNT_W + 1;
  localparam int ENT_W = 32 + TAG_W + 1;

  localparam logic [`RANGE_MODESC] MODESC_IDLE = {1'b1, 4'd0, 1'b0, 1'b0};

  // Issue state
  logic                      toggle;
  logic                      accept;
  logic [`RANGE_MODESC]      conv_desc;

  // In-flight tracker: stage [2] lines up with the ALU result phase
  logic [2:0]                trk_vld;
  logic [2:0]                trk_ph;
  logic [2:0][TAG_W-1:0]     trk_tag;

  // Capture decode
  logic [1:0]                exp_en;
  logic                      push;
  logic                      push_err;
  logic                      spurious;

  // Response FIFO: storage ring plus the registered head on RSP_*
  logic [ENT_W-1:0]          mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          mem_cnt;
  logic                      pop;
  logic                      out_free;
  logic                      take_mem;
  logic                      take_push;
  logic                      mem_wr;
  logic [TOT_W-1:0]          total;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign MO0_MASK = 1'b0;
  assign MO1_MASK = 1'b0;
  assign SRC0B    = '0;
  assign SRC1B    = '0;

  // Credit covers everything between accept and response pop.
  assign total = TOT_W'(trk_vld[0]) + TOT_W'(trk_vld[1]) + TOT_W'(trk_vld[2])
               + TOT_W'(mem_cnt) + TOT_W'(RSP_VALID);
  assign REQ_READY = (total < TOT_W'(DEPTH));

  assign accept    = REQ_VALID & REQ_READY;
  assign conv_desc = {1'b0, `MO_CONV, 1'b0, REQ_OP};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      toggle <= 1'b0;
      MO0    <= MODESC_IDLE;
      MO1    <= MODESC_IDLE;
      SRC0A  <= '0;
      SRC1A  <= '0;
    end else begin
      MO0 <= MODESC_IDLE;
      MO1 <= MODESC_IDLE;
      if (accept) begin
        toggle <= ~toggle;
        if (!toggle) begin
          MO0   <= conv_desc;
          SRC0A <= REQ_DATA;
        end else begin
          MO1   <= conv_desc;
          SRC1A <= REQ_DATA;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      trk_vld <= '0;
      trk_ph  <= '0;
      trk_tag <= '0;
    end else begin
      trk_vld <= {trk_vld[1:0], accept};
      trk_ph  <= {trk_ph[1:0], toggle};
      trk_tag <= {trk_tag[1:0], REQ_TAG};
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    exp_en   = 2'b00;
    push_err = 1'b0;
    spurious = 1'b0;
    if (trk_vld[2]) begin
      exp_en   = trk_ph[2] ? 2'b10 : 2'b01;
      push_err = (ALU_PHASE_EN != exp_en);
    end else begin
      spurious = (ALU_PHASE_EN != 2'b00);
    end
  end

  // A tracked op always produces an entry, flagged if its phase was wrong.
  assign push      = trk_vld[2];
  assign pop       = RSP_VALID & RSP_READY;
  assign out_free  = ~RSP_VALID | pop;
  assign take_mem  = out_free & (mem_cnt != '0);
  assign take_push = out_free & (mem_cnt == '0) & push;
  assign mem_wr    = push & ~take_push;

  // NOTE: storage is not reset; validity lives entirely in the pointers and count.
  always_ff @(posedge CLK) begin
    if (mem_wr) mem[wr_ptr] <= {ALU_DOUT, trk_tag[2], push_err};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
    end else begin
      if (mem_wr)   wr_ptr <= next_ptr(wr_ptr);
      if (take_mem) rd_ptr <= next_ptr(rd_ptr);
      if (mem_wr && !take_mem)      mem_cnt <= mem_cnt + CNT_W'(1);
      else if (!mem_wr && take_mem) mem_cnt <= mem_cnt - CNT_W'(1);
    end
  end

  // Head register; an empty FIFO lets a fresh capture bypass straight in.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_TAG   <= '0;
      RSP_ERR   <= 1'b0;
    end else if (take_mem) begin
      RSP_VALID                     <= 1'b1;
      {RSP_DATA, RSP_TAG, RSP_ERR}  <= mem[rd_ptr];
    end else if (take_push) begin
      RSP_VALID                     <= 1'b1;
      {RSP_DATA, RSP_TAG, RSP_ERR}  <= {ALU_DOUT, trk_tag[2], push_err};
    end else if (pop) begin
      RSP_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST)                     ERR <= 1'b0;
    else if (push_err || spurious) ERR <= 1'b1;
  end

endmodule

// File: tb/tb_mtsp_alu_conv_issue.sv
// Self-checking bench for mtsp_alu_conv_issue: behavioural ALU, in-order scoreboard
// and credit model, directed plan steps followed by randomized traffic.
`ifndef MTSP_MODESC_DEFS
`define MTSP_MODESC_DEFS
`define MODESC_W 7
`define RANGE_MODESC 6:0
`define MO_CONV 4'd9
`endif

module tb_mtsp_alu_conv_issue;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam logic [6:0] MO_IDLE = 7'b100_0000;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              REQ_OP = 1'b0;
  logic [31:0]       REQ_DATA = '0;
  logic [TAG_W-1:0]  REQ_TAG = '0;
  logic [6:0]        MO0, MO1;
  logic              MO0_MASK, MO1_MASK;
  logic [31:0]       SRC0A, SRC0B, SRC1A, SRC1B;
  logic [1:0]        ALU_PHASE_EN = 2'b00;
  logic [31:0]       ALU_DOUT = '0;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [31:0]       RSP_DATA;
  logic [TAG_W-1:0]  RSP_TAG;
  logic              RSP_ERR;
  logic              ERR;

  int n_vec = 0;
  int n_err = 0;

  logic rdy_dir = 1'b1;
  logic rdy_rand = 1'b0;
  logic rnd_bit = 1'b1;
  int   inj_req = 0;
  int   spur_req = 0;

  assign RSP_READY = rdy_rand ? rnd_bit : rdy_dir;

  always #5 CLK = ~CLK;

  mtsp_alu_conv_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_DATA(REQ_DATA), .REQ_TAG(REQ_TAG),
    .MO0(MO0), .MO1(MO1), .MO0_MASK(MO0_MASK), .MO1_MASK(MO1_MASK),
    .SRC0A(SRC0A), .SRC0B(SRC0B), .SRC1A(SRC1A), .SRC1B(SRC1B),
    .ALU_PHASE_EN(ALU_PHASE_EN), .ALU_DOUT(ALU_DOUT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_TAG(RSP_TAG), .RSP_ERR(RSP_ERR), .ERR(ERR)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Conversion formats: float = {9'b0, 7-bit exponent (bias 63), 16-bit fraction}.
  function automatic logic [31:0] int_to_fp(input logic [31:0] x);
    int p;
    logic [31:0] m;
    if (x == 32'd0) return 32'd0;
    p = 31;
    while (!x[p]) p--;
    if (p >= 16) m = x >> (p - 16);
    else         m = x << (16 - p);
    return {9'd0, 7'(p + 63), m[15:0]};
  endfunction

  function automatic logic [31:0] fp_to_int(input logic [31:0] f);
    int e;
    logic [63:0] m;
    e = int'(f[22:16]) - 79;
    m = {47'd0, 1'b1, f[15:0]};
    if (e < -17) return 32'd0;
    if (e >= 0) m = m << e;
    else        m = m >> (-e);
    return m[31:0];
  endfunction

  function automatic logic [31:0] conv(input logic op, input logic [31:0] d);
    return op ? int_to_fp(d) : fp_to_int(d);
  endfunction

  always @(posedge CLK) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Behavioural ALU: result phase two cycles after the micro-op is seen.
  typedef struct packed { logic [1:0] en; logic [31:0] d; } alu_t;
  alu_t ap0, ap1;
  int   inj_alu_seen = 0;
  int   spur_seen = 0;

  always @(negedge CLK) begin
    if (!nRST) begin
      ap0 = '0;
      ap1 = '0;
      ALU_PHASE_EN = 2'b00;
      ALU_DOUT = $urandom;
    end else begin
      ALU_PHASE_EN = ap1.en;
      ALU_DOUT = (ap1.en != 2'b00) ? ap1.d : $urandom;
      if (spur_req != spur_seen) begin
        ALU_PHASE_EN = 2'b01;
        spur_seen = spur_req;
      end
      ap1 = ap0;
      ap0 = '0;
      if (!MO0[6]) begin
        ap0.en = 2'b01;
        ap0.d  = conv(MO0[0], SRC0A);
      end else if (!MO1[6]) begin
        ap0.en = 2'b10;
        ap0.d  = conv(MO1[0], SRC1A);
        if (inj_req != inj_alu_seen) begin
          ap0.en = 2'b01;
          inj_alu_seen = inj_req;
        end
      end
    end
  end

  // Scoreboard, credit model and issue-slot model.
  typedef struct { logic [31:0] d; logic [TAG_W-1:0] t; logic e; } rsp_t;
  rsp_t             exp_q[$];
  int               outstanding = 0;
  int               inj_sb_seen = 0;
  logic             acc_tog = 1'b0;
  logic [6:0]       pend_mo0 = MO_IDLE, pend_mo1 = MO_IDLE;
  logic [31:0]      pend_src0 = '0, pend_src1 = '0;
  logic             hold_prev = 1'b0;
  logic [31:0]      hold_d;
  logic [TAG_W-1:0] hold_t;
  logic             hold_e;

  always @(negedge CLK) begin
    rsp_t e;
    if (!nRST) begin
      exp_q.delete();
      outstanding = 0;
      acc_tog = 1'b0;
      pend_mo0 = MO_IDLE;
      pend_mo1 = MO_IDLE;
      hold_prev = 1'b0;
    end else begin
      check("mo0", 64'(MO0), 64'(pend_mo0));
      check("mo1", 64'(MO1), 64'(pend_mo1));
      if (!pend_mo0[6]) check("src0a", 64'(SRC0A), 64'(pend_src0));
      if (!pend_mo1[6]) check("src1a", 64'(SRC1A), 64'(pend_src1));
      check("req_ready_credit", 64'(REQ_READY), 64'(outstanding < DEPTH));
      if (hold_prev) begin
        check("rsp_hold_valid", 64'(RSP_VALID), 64'd1);
        check("rsp_hold_data", 64'(RSP_DATA), 64'(hold_d));
        check("rsp_hold_tag", 64'(RSP_TAG), 64'(hold_t));
        check("rsp_hold_err", 64'(RSP_ERR), 64'(hold_e));
      end
      if (RSP_VALID && RSP_READY) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(RSP_TAG), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(RSP_DATA), 64'(e.d));
          check("rsp_tag", 64'(RSP_TAG), 64'(e.t));
          check("rsp_err", 64'(RSP_ERR), 64'(e.e));
        end
        outstanding--;
      end
      hold_prev = RSP_VALID && !RSP_READY;
      hold_d = RSP_DATA;
      hold_t = RSP_TAG;
      hold_e = RSP_ERR;
      pend_mo0 = MO_IDLE;
      pend_mo1 = MO_IDLE;
      if (REQ_VALID && REQ_READY) begin
        e.d = conv(REQ_OP, REQ_DATA);
        e.t = REQ_TAG;
        e.e = acc_tog && (inj_req != inj_sb_seen);
        if (e.e) inj_sb_seen = inj_req;
        exp_q.push_back(e);
        outstanding++;
        if (!acc_tog) begin
          pend_mo0  = {1'b0, `MO_CONV, 1'b0, REQ_OP};
          pend_src0 = REQ_DATA;
        end else begin
          pend_mo1  = {1'b0, `MO_CONV, 1'b0, REQ_OP};
          pend_src1 = REQ_DATA;
        end
        acc_tog = ~acc_tog;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ_VALID = 1'b0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic send(input logic op, input logic [31:0] d, input logic [TAG_W-1:0] tg);
    int n;
    n = 0;
    REQ_VALID = 1'b1;
    REQ_OP = op;
    REQ_DATA = d;
    REQ_TAG = tg;
    @(negedge CLK);
    while (!REQ_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'd0);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (outstanding != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic took;
    int   nacc;

    // 1: reset state
    do_reset();
    check("rst_mo0", 64'(MO0), 64'(MO_IDLE));
    check("rst_mo1", 64'(MO1), 64'(MO_IDLE));
    check("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    check("rst_rsp_data", 64'(RSP_DATA), 64'd0);
    check("rst_rsp_tag", 64'(RSP_TAG), 64'd0);
    check("rst_rsp_err", 64'(RSP_ERR), 64'd0);
    check("rst_req_ready", 64'(REQ_READY), 64'd1);
    check("rst_err", 64'(ERR), 64'd0);

    // 2: fp->int on phase 0, 4-cycle response latency
    rdy_dir = 1'b1;
    send(1'b0, 32'h004F_8000, 4'd3);
    check("t2_mo0", 64'(MO0), 64'({1'b0, `MO_CONV, 1'b0, 1'b0}));
    check("t2_mo1_idle", 64'(MO1), 64'(MO_IDLE));
    check("t2_src0a", 64'(SRC0A), 64'h004F_8000);
    check("t2_src0b", 64'(SRC0B), 64'd0);
    check("t2_mask", 64'({MO0_MASK, MO1_MASK}), 64'd0);
    tick();
    tick();
    check("t2_rsp_not_yet", 64'(RSP_VALID), 64'd0);
    tick();
    check("t2_rsp_valid", 64'(RSP_VALID), 64'd1);
    check("t2_rsp_data", 64'(RSP_DATA), 64'h0001_8000);
    check("t2_rsp_tag", 64'(RSP_TAG), 64'd3);
    check("t2_rsp_err", 64'(RSP_ERR), 64'd0);
    wait_drain(20);

    // 3: int->fp on phase 1
    send(1'b1, 32'h0000_0100, 4'd5);
    check("t3_mo1", 64'(MO1), 64'({1'b0, `MO_CONV, 1'b0, 1'b1}));
    check("t3_mo0_idle", 64'(MO0), 64'(MO_IDLE));
    check("t3_src1a", 64'(SRC1A), 64'h0000_0100);
    check("t3_src1b", 64'(SRC1B), 64'd0);
    repeat (3) tick();
    check("t3_rsp_valid", 64'(RSP_VALID), 64'd1);
    check("t3_rsp_data", 64'(RSP_DATA), 64'h0047_0000);
    wait_drain(20);

    // 4: four back-to-back requests, responses on consecutive cycles
    for (int i = 0; i < 4; i++) send(i[0], $urandom, 4'(i));
    for (int i = 0; i < 4; i++) begin
      check("t4_rsp_valid", 64'(RSP_VALID), 64'd1);
      check("t4_rsp_tag", 64'(RSP_TAG), 64'(i));
      tick();
    end
    wait_drain(20);

    // 5: backpressure fills credit, then drains in order
    rdy_dir = 1'b0;
    nacc = 0;
    REQ_VALID = 1'b1;
    REQ_OP = 1'b1;
    REQ_TAG = 4'd8;
    REQ_DATA = $urandom;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      took = REQ_READY;
      @(posedge CLK);
      #1;
      if (took) begin
        nacc++;
        REQ_TAG = REQ_TAG + 4'd1;
        REQ_DATA = $urandom;
      end
    end
    REQ_VALID = 1'b0;
    check("t5_accepts", 64'(nacc), 64'(DEPTH));
    check("t5_ready_low", 64'(REQ_READY), 64'd0);
    rdy_dir = 1'b1;
    check("t5_ready_at_pop", 64'(REQ_READY), 64'd0);
    tick();
    check("t5_ready_after_pop", 64'(REQ_READY), 64'd1);
    wait_drain(30);

    // Randomized traffic with random response backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 1) == 0)
        send(1'b0, {9'd0, 7'($urandom_range(40, 100)), 16'($urandom)}, 4'($urandom));
      else
        send(1'b1, $urandom >> $urandom_range(0, 31), 4'($urandom));
    end
    wait_drain(400);
    rdy_rand = 1'b0;
    check("rand_err_clean", 64'(ERR), 64'd0);

    // Reset mid-operation drops in-flight and buffered work
    rdy_dir = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, $urandom, 4'(i));
    do_reset();
    rdy_dir = 1'b1;
    check("mid_rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    check("mid_rst_req_ready", 64'(REQ_READY), 64'd1);
    repeat (6) tick();
    check("mid_rst_quiet", 64'(RSP_VALID), 64'd0);
    check("mid_rst_err", 64'(ERR), 64'd0);

    // 6: phase mismatch flags the response and sets sticky ERR
    send(1'b0, 32'h004F_8000, 4'd1);
    wait_drain(20);
    inj_req++;
    send(1'b1, 32'h0000_1234, 4'd2);
    wait_drain(20);
    check("t6_err_set", 64'(ERR), 64'd1);
    for (int i = 0; i < 6; i++) send(i[0], $urandom, 4'(i + 4));
    wait_drain(40);
    check("t6_err_sticky", 64'(ERR), 64'd1);
    do_reset();
    check("t6_err_cleared", 64'(ERR), 64'd0);
    spur_req++;
    repeat (4) tick();
    check("t6_spur_err", 64'(ERR), 64'd1);
    check("t6_spur_no_rsp", 64'(RSP_VALID), 64'd0);
    check("t6_spur_ready", 64'(REQ_READY), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
